// File: rtl/frame_burst_addr_gen.sv
// Read-side frame walker: requests a buffer from the mutex controller, then issues per-line bursts.
// Optional dropped-frame counter enabled by defining MBUF_OVERRUN_CNT_EN.
module frame_burst_addr_gen #(
    parameter int C_ADDR_WIDTH      = 32,
    parameter int C_IMG_WBITS       = 12,
    parameter int C_IMG_HBITS       = 12,
    parameter int C_BYTES_PER_PIXEL = 4,
    parameter int C_BURST_PIXELS    = 16
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic [C_IMG_WBITS-1:0]                img_width,
    input  logic [C_IMG_HBITS-1:0]                img_height,
    input  logic [C_ADDR_WIDTH-1:0]               line_stride,
    input  logic                                  frame_start,
    output logic                                  buf_sof,
    input  logic [C_ADDR_WIDTH-1:0]               buf_addr,
    output logic                                  cmd_valid,
    input  logic                                  cmd_ready,
    output logic [C_ADDR_WIDTH-1:0]               cmd_addr,
    output logic [$clog2(C_BURST_PIXELS):0]       cmd_len,
    output logic                                  cmd_eol,
    output logic                                  cmd_eof,
    output logic                                  busy,
    output logic                                  frame_done,
    output logic [7:0]                            overrun_cnt
);

    localparam int LEN_W     = $clog2(C_BURST_PIXELS) + 1;
    localparam int BPP_SHIFT = $clog2(C_BYTES_PER_PIXEL);
    localparam logic [C_IMG_WBITS-1:0] BURST_W = C_IMG_WBITS'(C_BURST_PIXELS);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SOF   = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_CMD   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]              state_reg,     state_next;
    logic [C_IMG_WBITS-1:0]  width_reg,     width_next;
    logic [C_IMG_HBITS-1:0]  height_reg,    height_next;
    logic [C_ADDR_WIDTH-1:0] stride_reg,    stride_next;
    logic [C_ADDR_WIDTH-1:0] line_base_reg, line_base_next;
    logic [C_ADDR_WIDTH-1:0] cur_addr_reg,  cur_addr_next;
    logic [C_IMG_WBITS-1:0]  pix_rem_reg,   pix_rem_next;
    logic [C_IMG_HBITS-1:0]  line_rem_reg,  line_rem_next;

    logic [C_ADDR_WIDTH-1:0] addr_inc;
    logic [C_ADDR_WIDTH-1:0] next_line_base;
    logic                    valid_next;
    logic [LEN_W-1:0]        len_next;
    logic                    eol_next;
    logic                    eof_next;

    always_comb begin
        state_next     = state_reg;
        width_next     = width_reg;
        height_next    = height_reg;
        stride_next    = stride_reg;
        line_base_next = line_base_reg;
        cur_addr_next  = cur_addr_reg;
        pix_rem_next   = pix_rem_reg;
        line_rem_next  = line_rem_reg;
        addr_inc       = C_ADDR_WIDTH'(cmd_len) << BPP_SHIFT;
        next_line_base = line_base_reg + stride_reg;

        case (state_reg)
            ST_IDLE: begin
                if (frame_start) begin
                    width_next  = img_width;
                    height_next = img_height;
                    stride_next = line_stride;
                    state_next  = ST_SOF;
                end
            end
            ST_SOF: begin
                state_next = ST_LATCH;
            end
            ST_LATCH: begin
                line_base_next = buf_addr;
                cur_addr_next  = buf_addr;
                pix_rem_next   = width_reg;
                line_rem_next  = height_reg;
                if (width_reg == '0 || height_reg == '0)
                    state_next = ST_DONE;
                else
                    state_next = ST_CMD;
            end
            ST_CMD: begin
                // cmd_valid is always high in this state, so cmd_ready alone means acceptance
                if (cmd_ready) begin
                    if (cmd_eol) begin
                        line_base_next = next_line_base;
                        cur_addr_next  = next_line_base;
                        pix_rem_next   = width_reg;
                        line_rem_next  = line_rem_reg - C_IMG_HBITS'(1);
                        if (cmd_eof)
                            state_next = ST_DONE;
                    end else begin
                        pix_rem_next  = pix_rem_reg - C_IMG_WBITS'(cmd_len);
                        cur_addr_next = cur_addr_reg + addr_inc;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Command fields are derived from the next-state counters so every output stays registered.
    always_comb begin
        valid_next = (state_next == ST_CMD);
        len_next   = (pix_rem_next > BURST_W) ? LEN_W'(C_BURST_PIXELS) : LEN_W'(pix_rem_next);
        eol_next   = (pix_rem_next <= BURST_W);
        eof_next   = eol_next && (line_rem_next == C_IMG_HBITS'(1));
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg     <= ST_IDLE;
            width_reg     <= '0;
            height_reg    <= '0;
            stride_reg    <= '0;
            line_base_reg <= '0;
            cur_addr_reg  <= '0;
            pix_rem_reg   <= '0;
            line_rem_reg  <= '0;
            buf_sof       <= 1'b0;
            cmd_valid     <= 1'b0;
            cmd_addr      <= '0;
            cmd_len       <= '0;
            cmd_eol       <= 1'b0;
            cmd_eof       <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            width_reg     <= width_next;
            height_reg    <= height_next;
            stride_reg    <= stride_next;
            line_base_reg <= line_base_next;
            cur_addr_reg  <= cur_addr_next;
            pix_rem_reg   <= pix_rem_next;
            line_rem_reg  <= line_rem_next;
            buf_sof       <= (state_next == ST_SOF);
            busy          <= (state_next != ST_IDLE);
            frame_done    <= (state_next == ST_DONE);
            cmd_valid     <= valid_next;
            cmd_addr      <= valid_next ? cur_addr_next : '0;
            cmd_len       <= valid_next ? len_next : '0;
            cmd_eol       <= valid_next && eol_next;
            cmd_eof       <= valid_next && eof_next;
        end
    end

`ifdef MBUF_OVERRUN_CNT_EN
    logic [7:0] overrun_reg;

    always_ff @(posedge clk) begin
        if (!resetn)
            overrun_reg <= 8'd0;
        else if (frame_start && state_reg != ST_IDLE && overrun_reg != 8'hFF)
            overrun_reg <= overrun_reg + 8'd1;
    end

    assign overrun_cnt = overrun_reg;
`else
    assign overrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_frame_burst_addr_gen.sv
// Directed bench for frame_burst_addr_gen: a per-frame command list model is built with plain
// arithmetic and every accepted command is checked against it.
module tb_frame_burst_addr_gen;

    localparam int LEN_W = 5;

    typedef struct packed {
        logic [31:0]      addr;
        logic [LEN_W-1:0] len;
        logic             eol;
        logic             eof;
    } cmd_t;

    logic             clk;
    logic             resetn;
    logic [11:0]      img_width;
    logic [11:0]      img_height;
    logic [31:0]      line_stride;
    logic             frame_start;
    logic             buf_sof;
    logic [31:0]      buf_addr;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_eol;
    logic             cmd_eof;
    logic             busy;
    logic             frame_done;
    logic [7:0]       overrun_cnt;

    frame_burst_addr_gen dut (
        .clk         (clk),
        .resetn      (resetn),
        .img_width   (img_width),
        .img_height  (img_height),
        .line_stride (line_stride),
        .frame_start (frame_start),
        .buf_sof     (buf_sof),
        .buf_addr    (buf_addr),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_eol     (cmd_eol),
        .cmd_eof     (cmd_eof),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun_cnt (overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   acc_cnt = 0;
    int   sof_cnt = 0;
    int   done_cnt = 0;
    cmd_t exp_q[$];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Expected command list: each line cut into bursts of up to 16 pixels, 4 bytes per pixel.
    function automatic void build_model(input logic [11:0] w, input logic [11:0] h,
                                        input logic [31:0] s, input logic [31:0] base);
        cmd_t c;
        for (int l = 0; l < int'(h); l++) begin
            for (int p = 0; p < int'(w); p += 16) begin
                int len;
                len    = (int'(w) - p > 16) ? 16 : int'(w) - p;
                c.addr = base + s * 32'(l) + 32'(p * 4);
                c.len  = LEN_W'(len);
                c.eol  = (p + len == int'(w));
                c.eof  = c.eol && (l == int'(h) - 1);
                exp_q.push_back(c);
            end
        end
    endfunction

    initial begin : compare
        cmd_t cur;
        cmd_t prev_cmd;
        cmd_t e;
        bit   prev_stall;
        prev_stall = 1'b0;
        prev_cmd   = '0;
        forever begin
            @(negedge clk);
            cur = {cmd_addr, cmd_len, cmd_eol, cmd_eof};
            if (!resetn) begin
                prev_stall = 1'b0;
            end else begin
                if (buf_sof) sof_cnt++;
                if (frame_done) done_cnt++;
                if (prev_stall) begin
                    n_cmp++;
                    if (!cmd_valid || cur !== prev_cmd) begin
                        n_err++;
                        $display("FAIL cmd_hold: got valid=%0b %h required valid=1 %h", cmd_valid, cur, prev_cmd);
                    end
                end
                if (cmd_valid && cmd_ready) begin
                    n_cmp++;
                    $display("cmd addr=%h len=%0d eol=%0b eof=%0b", cmd_addr, cmd_len, cmd_eol, cmd_eof);
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL cmd_extra: got %h required no command", cur);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            n_err++;
                            $display("FAIL cmd: got addr=%h len=%0d eol=%0b eof=%0b required addr=%h len=%0d eol=%0b eof=%0b",
                                     cmd_addr, cmd_len, cmd_eol, cmd_eof, e.addr, e.len, e.eol, e.eof);
                        end
                    end
                    acc_cnt++;
                end
                prev_stall = cmd_valid && !cmd_ready;
                prev_cmd   = cur;
            end
        end
    end

    task automatic run_frame(input logic [11:0] w, input logic [11:0] h, input logic [31:0] s,
                             input logic [31:0] base, input int stall_idx, input int stall_n,
                             input logic [31:0] stall_lit, input bit inject);
        int  acc_base;
        int  sof_base;
        int  stall_left;
        bit  injected;
        bit  got_done;
        bit  nonempty;
        acc_base   = acc_cnt;
        sof_base   = sof_cnt;
        stall_left = stall_n;
        injected   = 1'b0;
        got_done   = 1'b0;
        nonempty   = (w != 0) && (h != 0);
        build_model(w, h, s, base);
        img_width   = w;
        img_height  = h;
        line_stride = s;
        buf_addr    = 32'hDEAD_BEEF;
        cmd_ready   = 1'b1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        chk("sof_cycle", {61'd0, buf_sof, busy, cmd_valid}, {61'd0, 3'b110});
        @(posedge clk); #1;
        buf_addr = base;
        chk("latch_cycle", {62'd0, buf_sof, cmd_valid}, 64'd0);
        @(posedge clk); #1;
        chk("first_cmd_latency", {62'd0, cmd_valid, frame_done}, {62'd0, nonempty, !nonempty});
        for (int c = 0; c < 2000 && !got_done; c++) begin
            if (frame_done) begin
                got_done = 1'b1;
            end else begin
                if (stall_left > 0 && cmd_valid && acc_cnt - acc_base == stall_idx) begin
                    cmd_ready = 1'b0;
                    stall_left--;
                    if (stall_lit != 32'd0)
                        chk("stall_literal", {27'd0, cmd_addr, cmd_len}, {27'd0, stall_lit, 5'd16});
                end else begin
                    cmd_ready = 1'b1;
                end
                if (inject && !injected && acc_cnt - acc_base == 2) begin
                    frame_start = 1'b1;
                    injected    = 1'b1;
                end else begin
                    frame_start = 1'b0;
                end
                @(posedge clk); #1;
            end
        end
        frame_start = 1'b0;
        chk("frame_done_seen", {63'd0, got_done}, 64'd1);
        chk("all_cmds_issued", 64'(exp_q.size()), 64'd0);
        chk("one_buf_sof", 64'(sof_cnt - sof_base), 64'd1);
        exp_q.delete();
        @(posedge clk); #1;
        chk("idle_after_done", {62'd0, busy, frame_done}, 64'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int  acc_base;
        int  done_base;
        bit  reached;
        logic [7:0] exp_ovr;
        resetn      = 1'b0;
        img_width   = '0;
        img_height  = '0;
        line_stride = '0;
        frame_start = 1'b0;
        buf_addr    = '0;
        cmd_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {buf_sof, cmd_valid, cmd_addr, cmd_len, cmd_eol, cmd_eof, busy, frame_done, overrun_cnt},
            64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("idle_outputs", {buf_sof, cmd_valid, busy, frame_done, overrun_cnt}, 64'd0);

        // Pin the model against hand-computed commands.
        build_model(12'd40, 12'd2, 32'h100, 32'h1000_0000);
        chk("model_count", 64'(exp_q.size()), 64'd6);
        chk("model_cmd2", 64'(exp_q[2]), 64'({32'h1000_0080, 5'd8, 1'b1, 1'b0}));
        chk("model_cmd5", 64'(exp_q[5]), 64'({32'h1000_0180, 5'd8, 1'b1, 1'b1}));
        exp_q.delete();
        build_model(12'd32, 12'd1, 32'h0, 32'hFFFF_FFC0);
        chk("model_wrap0", 64'(exp_q[0]), 64'({32'hFFFF_FFC0, 5'd16, 1'b0, 1'b0}));
        chk("model_wrap1", 64'(exp_q[1]), 64'({32'h0000_0000, 5'd16, 1'b1, 1'b1}));
        exp_q.delete();

        run_frame(12'd40, 12'd2, 32'h100, 32'h1000_0000, -1, 0, 32'd0, 1'b0);
        run_frame(12'd40, 12'd2, 32'h100, 32'h1000_0000, 1, 5, 32'h1000_0040, 1'b0);
        run_frame(12'd40, 12'd2, 32'h100, 32'h1000_0000, -1, 0, 32'd0, 1'b1);
`ifdef MBUF_OVERRUN_CNT_EN
        exp_ovr = 8'd1;
`else
        exp_ovr = 8'd0;
`endif
        chk("overrun_cnt", 64'(overrun_cnt), 64'(exp_ovr));
        run_frame(12'd0, 12'd4, 32'h100, 32'h2000_0000, -1, 0, 32'd0, 1'b0);
        run_frame(12'd5, 12'd0, 32'h100, 32'h2000_0000, -1, 0, 32'd0, 1'b0);
        run_frame(12'd32, 12'd1, 32'h80, 32'hFFFF_FFC0, -1, 0, 32'd0, 1'b0);
        run_frame(12'd16, 12'd1, 32'h80, 32'h0000_1000, -1, 0, 32'd0, 1'b0);
        run_frame(12'd1, 12'd3, 32'h20, 32'h3000_0000, -1, 0, 32'd0, 1'b0);
        run_frame(12'd37, 12'd3, 32'h1000, 32'h4000_0004, 2, 3, 32'd0, 1'b0);

        // Reset while the second command is on the bus.
        acc_base    = acc_cnt;
        reached     = 1'b0;
        build_model(12'd40, 12'd2, 32'h100, 32'h1000_0000);
        img_width   = 12'd40;
        img_height  = 12'd2;
        line_stride = 32'h100;
        buf_addr    = 32'h1000_0000;
        cmd_ready   = 1'b1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        for (int c = 0; c < 20 && !reached; c++) begin
            if (acc_cnt - acc_base >= 1 && cmd_valid) reached = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("reach_second_cmd", {63'd0, reached}, 64'd1);
        done_base = done_cnt;
        resetn    = 1'b0;
        cmd_ready = 1'b0;
        @(posedge clk); #1;
        chk("reset_midframe", {61'd0, cmd_valid, busy, frame_done}, 64'd0);
        chk("reset_overrun", 64'(overrun_cnt), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        exp_q.delete();
        repeat (10) @(posedge clk);
        #1;
        chk("no_done_after_reset", 64'(done_cnt - done_base), 64'd0);
        run_frame(12'd40, 12'd2, 32'h100, 32'h1000_0000, -1, 0, 32'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/frame_burst_addr_gen.md
# frame_burst_addr_gen

Read-side client of the mutex buffer controller: on each frame start it pulses the controller's reader SOF and captures the buffer base address the controller returns. It then walks the frame line by line and issues burst commands (address, pixel count) to the downstream memory-read master over a valid/ready handshake. It sits between the video timing source and the read DMA, one instance per reader port.

## Interface
- C_ADDR_WIDTH, 32, width of buffer/command addresses (bytes)
- C_IMG_WBITS, 12, width of image width field (pixels)
- C_IMG_HBITS, 12, width of image height field (lines)
- C_BYTES_PER_PIXEL, 4, byte size of one pixel; power of two
- C_BURST_PIXELS, 16, max pixels per command; power of two
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- img_width  in  C_IMG_WBITS  pixels per line; latched at frame start
- img_height  in  C_IMG_HBITS  lines per frame; latched at frame start
- line_stride  in  C_ADDR_WIDTH  byte offset between line starts; latched at frame start
- frame_start  in  1  single-cycle frame-begin pulse from timing source
- buf_sof  out  1  reader SOF to buffer controller
- buf_addr  in  C_ADDR_WIDTH  reader address from buffer controller
- cmd_valid  out  1  command valid
- cmd_ready  in  1  command accepted when high with cmd_valid
- cmd_addr  out  C_ADDR_WIDTH  burst start byte address
- cmd_len  out  log2(C_BURST_PIXELS)+1  burst length in pixels, 1..C_BURST_PIXELS
- cmd_eol  out  1  command is last of its line
- cmd_eof  out  1  command is last of frame
- busy  out  1  frame in progress
- frame_done  out  1  single-cycle pulse after last command accepted
- overrun_cnt  out  8  dropped frame_start count (see Configuration)

## Operation
- FSM states: IDLE, SOF, LATCH, CMD, DONE.
- IDLE: frame_start=1 -> latch img_width/img_height/line_stride, go SOF.
- SOF: buf_sof=1 for exactly this cycle; go LATCH.
- LATCH: sample buf_addr into line_base and cur_addr; pix_rem=width, line_rem=height; if width==0 or height==0 go DONE, else CMD.
- CMD: cmd_valid=1; cmd_len=min(C_BURST_PIXELS, pix_rem); cmd_eol when cmd_len==pix_rem; cmd_eof when cmd_eol and line_rem==1. On accept: pix_rem-=cmd_len, cur_addr+=cmd_len*C_BYTES_PER_PIXEL; if eol then line_base+=line_stride, cur_addr=new line_base, pix_rem=width, line_rem-=1; if eof go DONE.
- DONE: frame_done=1 for this cycle; go IDLE.
- All address arithmetic modulo 2^C_ADDR_WIDTH (wraps silently).
- cmd_addr/cmd_len/cmd_eol/cmd_eof held stable while cmd_valid=1 and cmd_ready=0; cmd_valid never deasserts without acceptance.
- busy=1 in SOF, LATCH, CMD, DONE.
- frame_start outside IDLE: ignored (frame dropped); frame in progress unaffected.
- frame_start in DONE cycle also ignored; a new frame needs frame_start while in IDLE.

## Timing
- Reset: all outputs 0 (buf_sof, cmd_valid, cmd_addr, cmd_len, cmd_eol, cmd_eof, busy, frame_done, overrun_cnt); FSM to IDLE. Reset mid-frame drops any pending command; no frame_done issued.
- frame_start sampled at edge E0 -> buf_sof high in cycle E0..E1 -> controller updates address at E1 -> buf_addr sampled at E2 -> cmd_valid high from E2 onward (3 cycles after frame_start seen).
- Back-to-back commands: one per cycle when cmd_ready held high.
- frame_done asserted the cycle after final acceptance; IDLE the cycle after that.
- All outputs registered.

## Configuration
- MBUF_OVERRUN_CNT_EN defined: overrun_cnt increments (saturating at 255) on each ignored frame_start; cleared only by reset.
- Not defined: overrun_cnt tied to 0; no counter logic.

## Test plan
- width=40, height=2, stride=0x100, buf_addr=0x1000_0000 -> cmds (0x1000_0000,16), (0x1000_0040,16), (0x1000_0080,8,eol), (0x1000_0100,16), (0x1000_0140,16), (0x1000_0180,8,eol,eof); frame_done next cycle.
- Same frame with cmd_ready low 5 cycles on 2nd cmd -> cmd_valid stays 1, cmd_addr=0x1000_0040, cmd_len=16 stable throughout; sequence unchanged.
- frame_start pulsed during CMD -> no extra buf_sof, frame completes normally; overrun_cnt=1 with MBUF_OVERRUN_CNT_EN, 0 without.
- width=0, height=4 -> one buf_sof pulse, no cmd_valid, frame_done 3 cycles after frame_start.
- buf_addr=0xFFFF_FFC0, width=32, height=1 -> cmds (0xFFFF_FFC0,16), (0x0000_0000,16,eol,eof).
- resetn low during 2nd cmd -> next cycle cmd_valid=0, busy=0, frame_done never pulses; subsequent frame_start restarts from buf_sof.
